// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   state_e   : memory-wait FSM encoding (RUN = 0, MEM_WAIT = 1)
//   CNT_W     : default width of the performance counters
//   NOP_*     : what a bubbled stage register loads
//   reg_hit() : one Decode source operand matching an Execute destination
package pipe_hazard_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam int          CNT_W    = 32;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [4:0]  NOP_RD   = 5'd0;

   function automatic logic reg_hit(input logic used, input logic [4:0] raddr,
                                    input logic [4:0] waddr);
      return used & (raddr == waddr);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard sources, receives stage controls
//   slave  : controller side
// Signal names keep their controller-relative _i/_o suffixes.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = pipe_hazard_ctrl_pkg::CNT_W
);
   logic [4:0]       D_reg_raddr1_i, D_reg_raddr2_i;
   logic             D_rs1_used_i, D_rs2_used_i;
   logic [4:0]       E_reg_waddr_i;
   logic             E_reg_wen_i, E_reg_mux_i, E_redirect_i;
   logic             imem_valid_i, dmem_req_i, dmem_ack_i;
   logic             F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o;
   logic             M_stall_o, M_bubble_o, W_stall_o, W_bubble_o;
   logic             pc_redirect_o, mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

   modport master (
      output D_reg_raddr1_i, D_reg_raddr2_i, D_rs1_used_i, D_rs2_used_i,
             E_reg_waddr_i, E_reg_wen_i, E_reg_mux_i, E_redirect_i,
             imem_valid_i, dmem_req_i, dmem_ack_i,
      input  F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
             M_stall_o, M_bubble_o, W_stall_o, W_bubble_o,
             pc_redirect_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  D_reg_raddr1_i, D_reg_raddr2_i, D_rs1_used_i, D_rs2_used_i,
             E_reg_waddr_i, E_reg_wen_i, E_reg_mux_i, E_redirect_i,
             imem_valid_i, dmem_req_i, dmem_ack_i,
      output F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
             M_stall_o, M_bubble_o, W_stall_o, W_bubble_o,
             pc_redirect_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_i : clock, async active-high reset (count -> 0)
//   clr_i        : clear to 0 (wins over inc_i)
//   inc_i        : add 1 unless already all-ones
//   cnt_o        : current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns memory waits, Execute redirects,
// load-use dependencies and fetch misses into per-stage stall/bubble
// controls, tracks long memory waits and counts stall/flush cycles.
//   clk_i, rst_i : clock, async active-high reset
//   hz (slave)   : hazard sources in, stage controls / status / counters out
// Parameters: TIMEOUT (1..255) memory-wait cycles before mem_timeout_o,
//             CNT_W performance counter width.
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = pipe_hazard_ctrl_pkg::CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   pipe_hazard_ctrl_if.slave hz
);
   import pipe_hazard_ctrl_pkg::*;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt;
   logic       tmo_q, tmo_d;
   logic       mem_wait, load_use;
   logic       f_stall, d_stall, d_bubble, e_stall, e_bubble;
   logic       m_stall, w_bubble, redirect;

   assign mem_wait = hz.dmem_req_i & ~hz.dmem_ack_i;

   assign load_use = hz.E_reg_mux_i & hz.E_reg_wen_i & (hz.E_reg_waddr_i != 5'd0) &
                     (reg_hit(hz.D_rs1_used_i, hz.D_reg_raddr1_i, hz.E_reg_waddr_i) |
                      reg_hit(hz.D_rs2_used_i, hz.D_reg_raddr2_i, hz.E_reg_waddr_i));

   // Only the highest-priority hazard drives the controls. A redirect under
   // a memory wait is not lost: Execute is frozen, so E_redirect_i is still
   // present in the first cycle after the wait ends.
   always_comb begin
      f_stall  = 1'b0;
      d_stall  = 1'b0;
      d_bubble = 1'b0;
      e_stall  = 1'b0;
      e_bubble = 1'b0;
      m_stall  = 1'b0;
      w_bubble = 1'b0;
      redirect = 1'b0;
      if (mem_wait) begin
         f_stall  = 1'b1;
         d_stall  = 1'b1;
         e_stall  = 1'b1;
         m_stall  = 1'b1;
         w_bubble = 1'b1;
      end else if (hz.E_redirect_i) begin
         redirect = 1'b1;
         d_bubble = 1'b1;
         e_bubble = 1'b1;
      end else if (load_use) begin
         f_stall  = 1'b1;
         d_stall  = 1'b1;
         e_bubble = 1'b1;
      end else if (!hz.imem_valid_i) begin
         f_stall  = 1'b1;
         d_bubble = 1'b1;
      end
   end

   assign hz.F_stall_o     = f_stall;
   assign hz.D_stall_o     = d_stall;
   assign hz.D_bubble_o    = d_bubble;
   assign hz.E_stall_o     = e_stall;
   assign hz.E_bubble_o    = e_bubble;
   assign hz.M_stall_o     = m_stall;
   assign hz.M_bubble_o    = 1'b0;
   assign hz.W_stall_o     = 1'b0;
   assign hz.W_bubble_o    = w_bubble;
   assign hz.pc_redirect_o = redirect;

   // Memory-wait FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (mem_wait) state_d = MEM_WAIT;
         MEM_WAIT: if (hz.dmem_ack_i || !hz.dmem_req_i) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= RUN;
      else       state_q <= state_d;
   end

   // wait_cnt counts MEM_WAIT cycles already spent; the TIMEOUT-th cycle of
   // a still-pending access raises the sticky flag.
   sat_counter #(.W(8)) u_wait_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (state_q == RUN),
      .inc_i (state_q == MEM_WAIT),
      .cnt_o (wait_cnt)
   );

   assign tmo_d = tmo_q | ((state_q == MEM_WAIT) & (wait_cnt == TMO_LAST) & mem_wait);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tmo_q <= 1'b0;
      else       tmo_q <= tmo_d;
   end

   assign hz.mem_timeout_o = tmo_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (f_stall),
      .cnt_o (hz.stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (redirect),
      .cnt_o (hz.flush_cnt_o)
   );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: memory-wait cycles before mem_timeout_o sets (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have ports: clk_i in 1 (the only clock); rst_i in 1, asynchronous, active-high reset.
REQ-004 SHALL have ports: D_reg_raddr1_i, D_reg_raddr2_i in 5 (Decode source registers); D_rs1_used_i, D_rs2_used_i in 1 (source actually read).
REQ-005 SHALL have ports: E_reg_waddr_i in 5; E_reg_wen_i in 1; E_reg_mux_i in 1 (1 = load result writeback).
REQ-006 SHALL have port E_redirect_i in 1: taken branch or jump resolved in Execute.
REQ-007 SHALL have port imem_valid_i in 1: fetch data valid this cycle.
REQ-008 SHALL have ports: dmem_req_i in 1 (Memory-stage access); dmem_ack_i in 1 (access completes this cycle).
REQ-009 SHALL have outputs F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, M_bubble_o, W_stall_o, W_bubble_o, 1 bit each: controls for the stage registers (stall holds, bubble loads NOP; stall dominates inside each register).
REQ-010 SHALL have outputs pc_redirect_o 1 (PC takes the branch target); mem_timeout_o 1 (sticky error flag).
REQ-011 SHALL have outputs stall_cnt_o CNT_W (F-stall cycles) and flush_cnt_o CNT_W (redirects taken).

Function
REQ-012 Stall and bubble outputs SHALL be combinational from the inputs and state_q, with zero-cycle latency.
REQ-013 mem_wait = dmem_req_i & ~dmem_ack_i.
REQ-014 load_use = E_reg_mux_i & E_reg_wen_i & E_reg_waddr_i != 0 & ((D_rs1_used_i & raddr1 == waddr) | (D_rs2_used_i & raddr2 == waddr)).
REQ-015 Priority, highest first: mem_wait > E_redirect_i > load_use > ~imem_valid_i; only the highest active condition drives the outputs.
REQ-016 mem_wait SHALL assert F/D/E/M_stall_o and W_bubble_o; every other control SHALL be 0, including pc_redirect_o.
REQ-017 Redirect SHALL assert pc_redirect_o, D_bubble_o and E_bubble_o; F_stall_o SHALL be 0.
REQ-018 A redirect masked by mem_wait SHALL NOT be lost: Execute is held, so E_redirect_i persists and the redirect fires in the first cycle without mem_wait.
REQ-019 load_use SHALL assert F_stall_o, D_stall_o and E_bubble_o.
REQ-020 ~imem_valid_i SHALL assert F_stall_o and D_bubble_o.
REQ-021 M_bubble_o and W_stall_o SHALL be constant 0; they are ports for register uniformity.
REQ-022 FSM state_q {RUN, MEM_WAIT}: RUN->MEM_WAIT on mem_wait; MEM_WAIT->RUN on dmem_ack_i or ~dmem_req_i; other cases hold state.
REQ-023 wait_cnt (8 bit) SHALL clear in RUN and increment each MEM_WAIT cycle, saturating at 255.
REQ-024 mem_timeout_o SHALL set when in MEM_WAIT with wait_cnt == TIMEOUT-1 and mem_wait still high; it SHALL be cleared only by reset.
REQ-025 stall_cnt_o SHALL increment on each cycle with F_stall_o = 1, saturating at all-ones.
REQ-026 flush_cnt_o SHALL increment on each cycle with pc_redirect_o = 1, saturating at all-ones.
REQ-027 Outputs SHALL be X-free whenever inputs are known.

Reset
REQ-028 rst_i high SHALL immediately force state_q = RUN, wait_cnt = 0, mem_timeout_o = 0, stall_cnt_o = 0, flush_cnt_o = 0.
REQ-029 Combinational outputs during reset SHALL follow REQ-015..021 from the inputs.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abort the wait count, with no residual timeout.

Structure
REQ-031 The shared pipeline package SHALL hold the state enum (RUN = 0, MEM_WAIT = 1), the NOP bubble constants, and CNT_W.
REQ-032 The block SHALL contain one sub-module, sat_counter (parameterised width, inc and clear inputs), instantiated for wait_cnt, stall_cnt and flush_cnt.

Verification
REQ-033 Load-use: E load to x5, D raddr1 = 5 with rs1 used -> F_stall = D_stall = E_bubble = 1 for exactly 1 cycle; stall_cnt +1.
REQ-034 Load to x0: E_reg_waddr = 0, D raddr1 = 0 used -> all stall and bubble outputs 0.
REQ-035 Redirect plus load_use in the same cycle -> pc_redirect = D_bubble = E_bubble = 1, F_stall = 0; flush_cnt +1.
REQ-036 dmem_req = 1, ack low for 3 cycles with E_redirect = 1 throughout -> F/D/E/M stall and W_bubble for 3 cycles, pc_redirect 0; on ack cycle +1, pc_redirect = 1.
REQ-037 TIMEOUT = 4, ack withheld 10 cycles -> mem_timeout_o rises after the 4th MEM_WAIT cycle and stays 1 after ack; rst_i pulse clears it.
REQ-038 imem_valid = 0 for 2 cycles, no other hazard -> F_stall = D_bubble = 1 for 2 cycles; stall_cnt = 2.
